// File: rtl/ysyx_22040210_gshare_ctrl.sv
// Gshare pattern-history-table controller: owns the global history, sweeps the
// table clear after reset, and serialises commit-time counter updates.
module ysyx_22040210_gshare_ctrl #(
    parameter int BHRLEN = 8,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pred_valid,
    input  logic [PC_W-1:0]   pred_pc1,
    input  logic [PC_W-1:0]   pred_pc2,
    output logic              resp_valid1,
    output logic              resp_valid2,
    output logic              resp_taken1,
    output logic              resp_taken2,
    output logic [BHRLEN-1:0] cur_bhr,
    input  logic              spec_valid,
    input  logic              spec_taken,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic [BHRLEN-1:0] upd_bhr,
    input  logic              upd_taken,
    input  logic              upd_mispredict,
    output logic [BHRLEN-1:0] pht_raddr1,
    output logic [BHRLEN-1:0] pht_raddr2,
    input  logic [1:0]        pht_rdata1,
    input  logic [1:0]        pht_rdata2,
    output logic              pht_we,
    output logic [BHRLEN-1:0] pht_waddr,
    output logic [1:0]        pht_wdata,
    output logic              init_done
);

    // state  | meaning
    // INIT   | sweeping every table entry to weak not-taken
    // IDLE   | ready for a commit-time update
    // UPD_RD | port 2 reads the counter being updated
    // UPD_WR | saturated counter written back
    typedef enum logic [1:0] {INIT, IDLE, UPD_RD, UPD_WR} state_t;

    localparam logic [BHRLEN-1:0] ONE = {{(BHRLEN-1){1'b0}}, 1'b1};

    state_t            state, state_nxt;
    logic [BHRLEN-1:0] sweep_cnt;
    logic [BHRLEN-1:0] bhr;
    logic [BHRLEN-1:0] upd_idx;
    logic              upd_tk;
    logic [BHRLEN-1:0] idx1, idx2;
    logic              accept;
    logic              sweep_last;
    logic [1:0]        ctr_next;
    logic              unused_bits;

    assign idx1       = pred_pc1[BHRLEN+1:2] ^ bhr;
    assign idx2       = pred_pc2[BHRLEN+1:2] ^ bhr;
    assign accept     = upd_valid && (state == IDLE);
    assign sweep_last = &sweep_cnt;
    assign cur_bhr    = bhr;
    assign pht_raddr1 = idx1;
    assign resp_taken1 = resp_valid1 & pht_rdata1[1];
    assign resp_taken2 = resp_valid2 & pht_rdata2[1];
    assign unused_bits = ^{pred_pc1[PC_W-1:BHRLEN+2], pred_pc1[1:0],
                           pred_pc2[PC_W-1:BHRLEN+2], pred_pc2[1:0],
                           upd_pc[PC_W-1:BHRLEN+2], upd_pc[1:0], pht_rdata1[0]};

    always_comb begin
        ctr_next = pht_rdata2;
        if (upd_tk) begin
            if (pht_rdata2 != 2'b11) ctr_next = pht_rdata2 + 2'b01;
        end else begin
            if (pht_rdata2 != 2'b00) ctr_next = pht_rdata2 - 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= INIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        upd_ready  = 1'b0;
        pht_we     = 1'b0;
        pht_waddr  = '0;
        pht_wdata  = 2'b00;
        pht_raddr2 = idx2;
        case (state)
            INIT: begin
                pht_we    = 1'b1;
                pht_waddr = sweep_cnt;
                pht_wdata = 2'b01;
                if (sweep_last) state_nxt = IDLE;
            end
            IDLE: begin
                upd_ready = 1'b1;
                if (upd_valid) state_nxt = UPD_RD;
            end
            UPD_RD: begin
                pht_raddr2 = upd_idx;
                state_nxt  = UPD_WR;
            end
            UPD_WR: begin
                pht_we    = 1'b1;
                pht_waddr = upd_idx;
                pht_wdata = ctr_next;
                state_nxt = IDLE;
            end
            default: state_nxt = INIT;
        endcase
        // Reset must kill an in-flight table write at once, not at the next edge.
        if (rst) begin
            pht_we    = 1'b0;
            pht_waddr = '0;
            pht_wdata = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sweep_cnt   <= '0;
            bhr         <= '0;
            upd_idx     <= '0;
            upd_tk      <= 1'b0;
            resp_valid1 <= 1'b0;
            resp_valid2 <= 1'b0;
            init_done   <= 1'b0;
        end else begin
            if (state == INIT) sweep_cnt <= sweep_cnt + ONE;
            if (state == INIT && sweep_last) init_done <= 1'b1;
            resp_valid1 <= pred_valid && (state != INIT);
            resp_valid2 <= pred_valid && (state != INIT) && (state != UPD_RD);
            if (accept) begin
                upd_idx <= upd_pc[BHRLEN+1:2] ^ upd_bhr;
                upd_tk  <= upd_taken;
            end
            if (accept && upd_mispredict)
                bhr <= {upd_bhr[BHRLEN-2:0], upd_taken};
            else if (spec_valid && state != INIT)
                bhr <= {bhr[BHRLEN-2:0], spec_taken};
        end
    end

endmodule

// File: tb/tb_ysyx_22040210_gshare_ctrl.sv
// Bench for the gshare controller: behavioural table/history model with
// randomized traffic plus directed sweep, saturation, recovery and abort cases.
module tb_ysyx_22040210_gshare_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pred_valid = 1'b0;
    logic [31:0] pred_pc1 = '0, pred_pc2 = '0;
    logic        resp_valid1, resp_valid2, resp_taken1, resp_taken2;
    logic [7:0]  cur_bhr;
    logic        spec_valid = 1'b0, spec_taken = 1'b0;
    logic        upd_valid = 1'b0, upd_ready;
    logic [31:0] upd_pc = '0;
    logic [7:0]  upd_bhr = '0;
    logic        upd_taken = 1'b0, upd_mispredict = 1'b0;
    logic [7:0]  pht_raddr1, pht_raddr2, pht_waddr;
    logic [1:0]  pht_rdata1, pht_rdata2, pht_wdata;
    logic        pht_we, init_done;

    always #5 clk = ~clk;

    ysyx_22040210_gshare_ctrl #(.BHRLEN(8), .PC_W(32)) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_pc1(pred_pc1), .pred_pc2(pred_pc2),
        .resp_valid1(resp_valid1), .resp_valid2(resp_valid2),
        .resp_taken1(resp_taken1), .resp_taken2(resp_taken2),
        .cur_bhr(cur_bhr), .spec_valid(spec_valid), .spec_taken(spec_taken),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
        .upd_bhr(upd_bhr), .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
        .pht_raddr1(pht_raddr1), .pht_raddr2(pht_raddr2),
        .pht_rdata1(pht_rdata1), .pht_rdata2(pht_rdata2),
        .pht_we(pht_we), .pht_waddr(pht_waddr), .pht_wdata(pht_wdata),
        .init_done(init_done)
    );

    // Table memory: synchronous read, read-before-write, no reset.
    logic [1:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = 2'(3 - (i % 3));
    always @(posedge clk) begin
        if (pht_we) mem[pht_waddr] <= pht_wdata;
        pht_rdata1 <= mem[pht_raddr1];
        pht_rdata2 <= mem[pht_raddr2];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [1:0] ref_ctr [256];
    logic [7:0] m_bhr;
    int         since;
    logic [7:0] a_idx;
    logic       a_taken;
    logic       p_pred, p_t1, p_t2;
    int         p_since;

    function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
        int v;
        v = int'(c) + (t ? 1 : -1);
        if (v > 3) v = 3;
        if (v < 0) v = 0;
        return 2'(v);
    endfunction

    task automatic model_init();
        for (int i = 0; i < 256; i++) ref_ctr[i] = 2'b01;
        m_bhr = '0; since = 3; p_pred = 1'b0; p_since = 3;
        p_t1 = 1'b0; p_t2 = 1'b0; a_idx = '0; a_taken = 1'b0;
    endtask

    task automatic step(input logic pv, input logic [31:0] pc1, input logic [31:0] pc2,
                        input logic sv, input logic st, input logic uv,
                        input logic [31:0] upc, input logic [7:0] ubhr,
                        input logic ut, input logic um);
        logic [7:0] i1, i2;
        logic acc;
        @(negedge clk);
        pred_valid = pv; pred_pc1 = pc1; pred_pc2 = pc2;
        spec_valid = sv; spec_taken = st;
        upd_valid = uv; upd_pc = upc; upd_bhr = ubhr; upd_taken = ut; upd_mispredict = um;
        #1;
        i1 = pc1[9:2] ^ m_bhr;
        i2 = pc2[9:2] ^ m_bhr;
        check("cur_bhr", 32'(cur_bhr), 32'(m_bhr));
        check("raddr1", 32'(pht_raddr1), 32'(i1));
        check("raddr2", 32'(pht_raddr2), 32'(since == 1 ? a_idx : i2));
        check("upd_ready", 32'(upd_ready), 32'(since >= 3));
        check("resp_valid1", 32'(resp_valid1), 32'(p_pred));
        if (p_pred) check("resp_taken1", 32'(resp_taken1), 32'(p_t1));
        check("resp_valid2", 32'(resp_valid2), 32'(p_pred && p_since != 1));
        if (p_pred && p_since != 1) check("resp_taken2", 32'(resp_taken2), 32'(p_t2));
        check("pht_we", 32'(pht_we), 32'(since == 2));
        if (since == 2) begin
            check("pht_waddr", 32'(pht_waddr), 32'(a_idx));
            check("pht_wdata", 32'(pht_wdata), 32'(sat(ref_ctr[a_idx], a_taken)));
        end
        check("init_done", 32'(init_done), 32'd1);
        // advance the model past this clock edge
        p_pred = pv; p_since = since;
        p_t1 = ref_ctr[i1][1]; p_t2 = ref_ctr[i2][1];
        if (since == 2) ref_ctr[a_idx] = sat(ref_ctr[a_idx], a_taken);
        acc = uv && since >= 3;
        if (acc) begin
            a_idx = upc[9:2] ^ ubhr; a_taken = ut; since = 1;
            if (um) m_bhr = {ubhr[6:0], ut};
            else if (sv) m_bhr = {m_bhr[6:0], st};
        end else begin
            if (since < 3) since++;
            if (sv) m_bhr = {m_bhr[6:0], st};
        end
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
    endtask

    task automatic sweep(input int abort_at);
        int i;
        logic aborted;
        aborted = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        pred_valid = 0; spec_valid = 0; upd_valid = 0; upd_mispredict = 0;
        @(negedge clk);
        rst = 1'b0;
        i = 0;
        while (i < 256) begin
            #1;
            check("sweep_we", 32'(pht_we), 32'd1);
            check("sweep_waddr", 32'(pht_waddr), 32'(i));
            check("sweep_wdata", 32'(pht_wdata), 32'd1);
            check("sweep_ready", 32'(upd_ready), 32'd0);
            check("sweep_init_done", 32'(init_done), 32'd0);
            check("sweep_resp", 32'(resp_valid1 | resp_valid2), 32'd0);
            check("sweep_bhr", 32'(cur_bhr), 32'd0);
            if (i == abort_at && !aborted) begin
                rst = 1'b1;
                #1;
                check("abort_we", 32'(pht_we), 32'd0);
                @(negedge clk);
                @(negedge clk);
                check("abort_init_done", 32'(init_done), 32'd0);
                rst = 1'b0;
                aborted = 1'b1;
                i = 0;
            end else begin
                pred_valid = 1'($urandom); spec_valid = 1'($urandom);
                spec_taken = 1'($urandom); upd_valid = 1'($urandom);
                upd_mispredict = 1'($urandom);
                @(negedge clk);
                i++;
            end
        end
        #1;
        check("init_done_rise", 32'(init_done), 32'd1);
        check("post_sweep_we", 32'(pht_we), 32'd0);
        check("post_sweep_bhr", 32'(cur_bhr), 32'd0);
        check("post_sweep_resp", 32'(resp_valid1), 32'd0);
        pred_valid = 0; spec_valid = 0; upd_valid = 0; upd_mispredict = 0;
        model_init();
    endtask

    task automatic random_run(input int cycles);
        logic [31:0] upc;
        logic [7:0]  ubhr;
        for (int c = 0; c < cycles; c++) begin
            if ($urandom_range(0, 1) == 0) begin
                upc  = 32'h80000000 | (32'($urandom_range(0, 3)) << 2);
                ubhr = 8'($urandom_range(0, 1));
            end else begin
                upc  = $urandom;
                ubhr = 8'($urandom);
            end
            step(1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom),
                 1'($urandom), upc, ubhr, 1'($urandom), ($urandom_range(0, 7) == 0));
        end
    endtask

    initial begin
        model_init();
        sweep(-1);

        // prediction at pc 0x80000010 with an empty history hits index 0x04
        step(1'b1, 32'h80000010, 32'h80000014, 0, 0, 0, 32'h0, 8'h0, 0, 0);
        check("t2_raddr1", 32'(pht_raddr1), 32'h04);
        idle();
        check("t2_resp_valid1", 32'(resp_valid1), 32'd1);
        check("t2_resp_taken1", 32'(resp_taken1), 32'd0);

        // three taken updates saturate index 0x04: 10, 11, 11
        for (int k = 0; k < 3; k++) begin
            step(0, 32'h0, 32'h0, 0, 0, 1'b1, 32'h80000010, 8'h00, 1'b1, 0);
            idle();
            check("t3_ready_low", 32'(upd_ready), 32'd0);
            idle();
            check("t3_we", 32'(pht_we), 32'd1);
            check("t3_waddr", 32'(pht_waddr), 32'h04);
            check("t3_wdata", 32'(pht_wdata), (k == 0) ? 32'd2 : 32'd3);
        end

        // mispredict recovery wins over a same-cycle speculative shift
        step(0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h80000020, 8'h5A, 1'b1, 1'b1);
        idle();
        check("t4_bhr", 32'(cur_bhr), 32'hB5);
        idle();

        // port-2 response dropped only for the UPD_RD cycle
        step(1'b1, 32'h80000040, 32'h80000044, 0, 0, 1'b1, 32'h80000050, 8'h0, 1'b0, 0);
        step(1'b1, 32'h80000040, 32'h80000044, 0, 0, 0, 32'h0, 8'h0, 0, 0);
        step(1'b1, 32'h80000040, 32'h80000044, 0, 0, 0, 32'h0, 8'h0, 0, 0);
        check("t5_resp_valid2", 32'(resp_valid2), 32'd0);
        check("t5_resp_valid1", 32'(resp_valid1), 32'd1);
        step(1'b1, 32'h80000040, 32'h80000044, 0, 0, 0, 32'h0, 8'h0, 0, 0);
        check("t5_resp_valid2_back", 32'(resp_valid2), 32'd1);

        random_run(2000);

        // reset mid-sweep at address 0x40, then traffic again
        sweep(32'h40);
        random_run(300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
